// File: rtl/ext_domain_power_sequencer.sv
// Power sequencer for the external-subsystem power domains: one domain at a time,
// round-robin selection, with the switch/ack/isolation/reset handshake for each domain.
module ext_domain_power_sequencer #(
    parameter int unsigned N_DOMAINS     = 1,
    parameter int unsigned ISO_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ACK_TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_DOMAINS-1:0] domain_on_req_i,
    input  logic [N_DOMAINS-1:0] switch_ack_i,
    input  logic                 err_clr_i,
    output logic [N_DOMAINS-1:0] switch_o,
    output logic [N_DOMAINS-1:0] iso_o,
    output logic [N_DOMAINS-1:0] domain_rst_no,
    output logic [N_DOMAINS-1:0] domain_on_o,
    output logic [N_DOMAINS-1:0] timeout_o,
    output logic                 busy_o
);

    localparam int unsigned MAX_A   = (ACK_TIMEOUT > SETTLE_CYCLES) ? ACK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > ISO_CYCLES) ? MAX_A : ISO_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int unsigned PTR_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PU_ACK    = 3'd1;
    localparam logic [2:0] S_PU_SETTLE = 3'd2;
    localparam logic [2:0] S_PU_REL    = 3'd3;
    localparam logic [2:0] S_PD_ISO    = 3'd4;
    localparam logic [2:0] S_PD_RST    = 3'd5;
    localparam logic [2:0] S_PD_ACK    = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]           r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0]     r_cur, w_cur_nxt;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_nxt;
    logic [N_DOMAINS-1:0] r_sw, w_sw_nxt;
    logic [N_DOMAINS-1:0] r_iso, w_iso_nxt;
    logic [N_DOMAINS-1:0] r_rstn, w_rstn_nxt;
    logic [N_DOMAINS-1:0] r_on, w_on_nxt;
    logic [N_DOMAINS-1:0] r_to, w_to_nxt, w_to_set;
    logic                 r_busy;
    logic [N_DOMAINS-1:0] r_ack_m, r_ack_s;

    logic [N_DOMAINS-1:0]   w_pend_up, w_pend_dn, w_pend;
    logic [2*N_DOMAINS-1:0] w_rot;
    logic                   w_found;
    int unsigned            w_off, w_sel_idx;
    logic [N_DOMAINS-1:0]   w_sel_oh, w_cur_oh;
    logic                   w_sel_up, w_ack_cur;

    // Two-flop synchronizer for the asynchronous switch-cell acks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_m <= '0;
            r_ack_s <= '0;
        end else begin
            r_ack_m <= switch_ack_i;
            r_ack_s <= r_ack_m;
        end
    end

    assign w_pend_up = domain_on_req_i & ~r_on & ~r_to;
    assign w_pend_dn = ~domain_on_req_i & r_on;
    assign w_pend    = w_pend_up | w_pend_dn;
    assign w_rot     = {w_pend, w_pend} >> r_rr_ptr;

    // Round-robin pick: first pending domain at or after rr_ptr
    always_comb begin
        w_found   = 1'b0;
        w_off     = 0;
        w_sel_idx = 0;
        w_sel_oh  = '0;
        w_cur_oh  = '0;
        for (int unsigned j = 0; j < N_DOMAINS; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = j;
            end
        end
        w_sel_idx = 32'(r_rr_ptr) + w_off;
        if (w_sel_idx >= N_DOMAINS) begin
            w_sel_idx = w_sel_idx - N_DOMAINS;
        end
        for (int unsigned d = 0; d < N_DOMAINS; d++) begin
            w_sel_oh[d] = (w_sel_idx == d);
            w_cur_oh[d] = (r_cur == PTR_W'(d));
        end
        w_sel_up  = |(w_sel_oh & w_pend_up);
        w_ack_cur = |(r_ack_s & w_cur_oh);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_cur    <= '0;
            r_rr_ptr <= '0;
            r_sw     <= '0;
            r_iso    <= '1;
            r_rstn   <= '0;
            r_on     <= '0;
            r_to     <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cur    <= w_cur_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_sw     <= w_sw_nxt;
            r_iso    <= w_iso_nxt;
            r_rstn   <= w_rstn_nxt;
            r_on     <= w_on_nxt;
            r_to     <= w_to_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cur_nxt   = r_cur;
        w_rr_nxt    = r_rr_ptr;
        w_sw_nxt    = r_sw;
        w_iso_nxt   = r_iso;
        w_rstn_nxt  = r_rstn;
        w_on_nxt    = r_on;
        w_to_set    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_cur_nxt = PTR_W'(w_sel_idx);
                    w_cnt_nxt = '0;
                    if (w_sel_up) begin
                        w_sw_nxt    = r_sw | w_sel_oh;
                        w_state_nxt = S_PU_ACK;
                    end else begin
                        w_iso_nxt   = r_iso | w_sel_oh;
                        w_on_nxt    = r_on & ~w_sel_oh;
                        w_state_nxt = S_PD_ISO;
                    end
                end
            end
            S_PU_ACK: begin
                if (w_ack_cur) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PU_SETTLE;
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    // Give up: disconnect supply, leave iso and reset asserted
                    w_sw_nxt    = r_sw & ~w_cur_oh;
                    w_to_set    = w_cur_oh;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PU_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    w_rstn_nxt  = r_rstn | w_cur_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PU_REL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PU_REL: begin
                if (r_cnt == CNT_W'(ISO_CYCLES - 1)) begin
                    w_iso_nxt   = r_iso & ~w_cur_oh;
                    w_on_nxt    = r_on | w_cur_oh;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PD_ISO: begin
                if (r_cnt == CNT_W'(ISO_CYCLES - 1)) begin
                    w_rstn_nxt  = r_rstn & ~w_cur_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PD_RST;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PD_RST: begin
                w_sw_nxt    = r_sw & ~w_cur_oh;
                w_cnt_nxt   = '0;
                w_state_nxt = S_PD_ACK;
            end
            S_PD_ACK: begin
                if (!w_ack_cur) begin
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_to_set    = w_cur_oh;
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_rr_nxt    = (r_cur == PTR_W'(N_DOMAINS - 1)) ? '0 : r_cur + PTR_W'(1);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A timeout being set takes priority over a coincident clear
        w_to_nxt = (err_clr_i ? '0 : r_to) | w_to_set;
    end

    assign switch_o      = r_sw;
    assign iso_o         = r_iso;
    assign domain_rst_no = r_rstn;
    assign domain_on_o   = r_on;
    assign timeout_o     = r_to;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_ext_domain_power_sequencer.sv
// Directed bench: a 1-domain sequencer with a 15-edge ack model and a 3-domain
// sequencer with a 3-edge ack model, checked at hand-computed edges.
module tb_ext_domain_power_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       err_clr;
    logic       stuck1;

    logic [0:0] req1, ack1, sw1, iso1, rstn1, on1, to1;
    logic       busy1;
    logic [2:0] req3, ack3, sw3, iso3, rstn3, on3, to3;
    logic       busy3;

    logic [14:0] dl1;
    logic [2:0]  dl3 [0:2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ext_domain_power_sequencer #(.N_DOMAINS(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .domain_on_req_i(req1), .switch_ack_i(ack1),
        .err_clr_i(err_clr), .switch_o(sw1), .iso_o(iso1), .domain_rst_no(rstn1),
        .domain_on_o(on1), .timeout_o(to1), .busy_o(busy1)
    );

    ext_domain_power_sequencer #(.N_DOMAINS(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .domain_on_req_i(req3), .switch_ack_i(ack3),
        .err_clr_i(err_clr), .switch_o(sw3), .iso_o(iso3), .domain_rst_no(rstn3),
        .domain_on_o(on3), .timeout_o(to3), .busy_o(busy3)
    );

    // Switch-cell models: ack follows switch_o with a fixed edge delay
    always @(posedge clk) begin
        dl1    <= {dl1[13:0], sw1[0]};
        dl3[0] <= sw3;
        dl3[1] <= dl3[0];
        dl3[2] <= dl3[1];
    end
    assign ack1 = stuck1 ? 1'b0 : dl1[14];
    assign ack3 = dl3[2];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; err_clr = 1'b0; stuck1 = 1'b0;
        req1 = '0; req3 = '0;
        dl1 = '0; dl3[0] = '0; dl3[1] = '0; dl3[2] = '0;
        step(3);
        chk("rst_sw",   16'(sw3),   16'h0);
        chk("rst_iso",  16'(iso3),  16'h7);
        chk("rst_rstn", 16'(rstn3), 16'h0);
        chk("rst_on",   16'(on3),   16'h0);
        chk("rst_to",   16'(to3),   16'h0);
        chk("rst_busy", 16'(busy3), 16'h0);
        chk("rst_iso1", 16'(iso1),  16'h1);

        // Round-robin with three simultaneous requests
        rst = 1'b0; req3 = 3'b111;
        step(1);  chk("rr_e1_sw", 16'(sw3), 16'h1); chk("rr_e1_busy", 16'(busy3), 16'h1);
        step(18); chk("rr_e19_on", 16'(on3), 16'h1); chk("rr_e19_iso", 16'(iso3), 16'h6);
        step(1);  chk("rr_e20_busy", 16'(busy3), 16'h0); chk("rr_e20_sw", 16'(sw3), 16'h1);
        step(1);  chk("rr_e21_sw", 16'(sw3), 16'h3); chk("rr_e21_busy", 16'(busy3), 16'h1);
        step(18); chk("rr_e39_on", 16'(on3), 16'h3);
        step(1);  chk("rr_e40_sw", 16'(sw3), 16'h3); chk("rr_e40_busy", 16'(busy3), 16'h0);
        step(1);  chk("rr_e41_sw", 16'(sw3), 16'h7);
        step(18); chk("rr_e59_on", 16'(on3), 16'h7); chk("rr_e59_rstn", 16'(rstn3), 16'h7);
        step(1);  chk("rr_e60_busy", 16'(busy3), 16'h0);

        // Power-up of a single domain with the 15-edge ack model
        req1 = 1'b1;
        step(1);  chk("pu_sw", 16'(sw1), 16'h1); chk("pu_busy", 16'(busy1), 16'h1);
        step(25); chk("pu_rstn_early", 16'(rstn1), 16'h0);
        step(1);  chk("pu_rstn", 16'(rstn1), 16'h1); chk("pu_iso_held", 16'(iso1), 16'h1);
        step(3);  chk("pu_on_early", 16'(on1), 16'h0);
        step(1);  chk("pu_iso", 16'(iso1), 16'h0); chk("pu_on", 16'(on1), 16'h1);
        step(1);  chk("pu_idle", 16'(busy1), 16'h0);
        step(1);  chk("pu_idle2", 16'(busy1), 16'h0);

        // Power-down
        req1 = 1'b0;
        step(1);  chk("pd_iso", 16'(iso1), 16'h1); chk("pd_on", 16'(on1), 16'h0);
        step(3);  chk("pd_rstn_early", 16'(rstn1), 16'h1);
        step(1);  chk("pd_rstn", 16'(rstn1), 16'h0); chk("pd_sw_held", 16'(sw1), 16'h1);
        step(1);  chk("pd_sw", 16'(sw1), 16'h0);
        step(18); chk("pd_ack_busy", 16'(busy1), 16'h1);
        step(1);  chk("pd_idle", 16'(busy1), 16'h0); chk("pd_to", 16'(to1), 16'h0);

        // Ack stuck low: timeout, no retry until err_clr
        stuck1 = 1'b1; req1 = 1'b1;
        step(1);  chk("to_sw", 16'(sw1), 16'h1);
        step(63); chk("to_sw_held", 16'(sw1), 16'h1); chk("to_flag_early", 16'(to1), 16'h0);
        step(1);  chk("to_sw_drop", 16'(sw1), 16'h0); chk("to_flag", 16'(to1), 16'h1);
        chk("to_iso", 16'(iso1), 16'h1); chk("to_rstn", 16'(rstn1), 16'h0);
        step(20); chk("to_noretry_busy", 16'(busy1), 16'h0); chk("to_noretry_sw", 16'(sw1), 16'h0);
        err_clr = 1'b1;
        step(1);  err_clr = 1'b0; stuck1 = 1'b0;
        chk("clr_flag", 16'(to1), 16'h0); chk("clr_sw", 16'(sw1), 16'h0);
        step(1);  chk("retry_sw", 16'(sw1), 16'h1); chk("retry_busy", 16'(busy1), 16'h1);

        // Reset asserted in PU_SETTLE takes effect without a clock edge
        step(20); chk("settle_rstn", 16'(rstn1), 16'h0);
        rst = 1'b1;
        #1;
        chk("arst_sw", 16'(sw1), 16'h0); chk("arst_iso", 16'(iso1), 16'h1);
        chk("arst_rstn", 16'(rstn1), 16'h0); chk("arst_on", 16'(on1), 16'h0);
        chk("arst_busy", 16'(busy1), 16'h0); chk("arst_on3", 16'(on3), 16'h0);
        step(20);
        rst = 1'b0;
        step(1);  chk("rerun_sw", 16'(sw1), 16'h1);
        step(26); chk("rerun_rstn", 16'(rstn1), 16'h1);
        step(4);  chk("rerun_on", 16'(on1), 16'h1); chk("rerun_iso", 16'(iso1), 16'h0);

        // Request toggled mid power-up: finish, then power down
        step(1);
        req1 = 1'b0;
        step(30); chk("tg_off", 16'(on1), 16'h0); chk("tg_off_sw", 16'(sw1), 16'h0);
        req1 = 1'b1;
        step(22);
        req1 = 1'b0;
        chk("tg_mid_rstn", 16'(rstn1), 16'h0);
        step(5);  chk("tg_rstn", 16'(rstn1), 16'h1);
        step(4);  chk("tg_on", 16'(on1), 16'h1);
        step(1);  chk("tg_idle_on", 16'(on1), 16'h1); chk("tg_idle_busy", 16'(busy1), 16'h0);
        step(1);  chk("tg_pd_on", 16'(on1), 16'h0); chk("tg_pd_iso", 16'(iso1), 16'h1);
        chk("tg_pd_busy", 16'(busy1), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
